// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
//   in_valid/in_ready  : operand pair handshake (in_a, in_b)
//   out_valid/out_ready: result handshake (out_c, out_flags = {invalid, overflow, underflow})
// master = producer/consumer side, slave = the multiplier.
interface fp_mul_pipe_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_c;
   logic [2:0]   out_flags;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_c, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_c, out_flags
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (binary32 by default).
// Round-to-nearest-even, subnormals flushed to zero, canonical qNaN.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low
//   bus   : fp_mul_pipe_if.slave (in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_c/out_flags)
// Stages: S1 classify + exponent sum, S2 mantissa product, S3 normalise/round/pack.
// The whole pipe advances together whenever the output register is free or being drained.
module fp_mul_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic         clk,
   input  logic         rst_n,
   fp_mul_pipe_if.slave bus
);

   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned EW   = EXP_W + 2;
   localparam int unsigned SW   = MAN_W + 1;
   localparam int unsigned PW   = 2 * MAN_W + 2;
   localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned EMAX = (1 << EXP_W) - 1;

   // Operand class summary carried down the pipe; result precedence is nan > inf > zero.
   typedef struct packed {
      logic nan;
      logic inv;
      logic inf;
      logic zero;
   } cls_t;

   logic          adv_c;

   logic          v1_q,     v1_d;
   logic          sign1_q,  sign1_d;
   logic [EW-1:0] exp1_q,   exp1_d;
   logic [SW-1:0] ma1_q,    ma1_d;
   logic [SW-1:0] mb1_q,    mb1_d;
   cls_t          cls1_q,   cls1_d;

   logic          v2_q,     v2_d;
   logic          sign2_q,  sign2_d;
   logic [EW-1:0] exp2_q,   exp2_d;
   logic [PW-1:0] prod2_q,  prod2_d;
   cls_t          cls2_q,   cls2_d;

   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_c_q,     out_c_d;
   logic [2:0]    out_flags_q, out_flags_d;

   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   logic             msb;
   logic [MAN_W-1:0] frac_n;
   logic             guard, sticky, rnd;
   logic [EW-1:0]    exp_n, exp_r;
   logic [SW-1:0]    mant_r;
   logic             ovf, unf;

   assign adv_c         = ~out_valid_q | bus.out_ready;
   assign bus.in_ready  = adv_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_c     = out_c_q;
   assign bus.out_flags = out_flags_q;

   // Next-state for all three stages; every register holds when the pipe is stalled.
   always_comb begin
      v1_d        = v1_q;
      sign1_d     = sign1_q;
      exp1_d      = exp1_q;
      ma1_d       = ma1_q;
      mb1_d       = mb1_q;
      cls1_d      = cls1_q;
      v2_d        = v2_q;
      sign2_d     = sign2_q;
      exp2_d      = exp2_q;
      prod2_d     = prod2_q;
      cls2_d      = cls2_q;
      out_valid_d = out_valid_q;
      out_c_d     = out_c_q;
      out_flags_d = out_flags_q;

      // S1: unpack and classify
      a_exp  = bus.in_a[W-2 -: EXP_W];
      b_exp  = bus.in_b[W-2 -: EXP_W];
      a_frac = bus.in_a[MAN_W-1:0];
      b_frac = bus.in_b[MAN_W-1:0];
      a_zero = (a_exp == '0);
      b_zero = (b_exp == '0);
      a_nan  = (&a_exp) & (|a_frac);
      b_nan  = (&b_exp) & (|b_frac);
      a_inf  = (&a_exp) & ~(|a_frac);
      b_inf  = (&b_exp) & ~(|b_frac);

      // S3: normalise by at most one place, then round to nearest even
      msb    = prod2_q[PW-1];
      frac_n = msb ? prod2_q[PW-2 -: MAN_W] : prod2_q[PW-3 -: MAN_W];
      guard  = msb ? prod2_q[PW-2-MAN_W]    : prod2_q[PW-3-MAN_W];
      sticky = msb ? (|prod2_q[PW-3-MAN_W:0]) : (|prod2_q[PW-4-MAN_W:0]);
      exp_n  = exp2_q + EW'(msb);
      rnd    = guard & (sticky | frac_n[0]);
      mant_r = {1'b0, frac_n} + SW'(rnd);
      // A rounding carry leaves the fraction bits at zero, so only the exponent moves.
      exp_r  = exp_n + EW'(mant_r[MAN_W]);
      ovf    = $signed(exp_r) >= $signed(EW'(EMAX));
      unf    = exp_r[EW-1] | (exp_r == '0);

      if (adv_c) begin
         v1_d        = bus.in_valid;
         sign1_d     = bus.in_a[W-1] ^ bus.in_b[W-1];
         exp1_d      = EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
         ma1_d       = {1'b1, a_frac};
         mb1_d       = {1'b1, b_frac};
         cls1_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
         cls1_d.inv  = ~(a_nan | b_nan) & ((a_inf & b_zero) | (a_zero & b_inf));
         cls1_d.inf  = a_inf | b_inf;
         cls1_d.zero = a_zero | b_zero;

         v2_d    = v1_q;
         sign2_d = sign1_q;
         exp2_d  = exp1_q;
         prod2_d = PW'(ma1_q) * PW'(mb1_q);
         cls2_d  = cls1_q;

         out_valid_d = v2_q;
         if (cls2_q.nan) begin
            out_c_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            out_flags_d = {cls2_q.inv, 2'b00};
         end else if (cls2_q.inf) begin
            out_c_d     = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            out_flags_d = 3'b000;
         end else if (cls2_q.zero) begin
            out_c_d     = {sign2_q, {(W-1){1'b0}}};
            out_flags_d = 3'b000;
         end else if (ovf) begin
            out_c_d     = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            out_flags_d = 3'b010;
         end else if (unf) begin
            out_c_d     = {sign2_q, {(W-1){1'b0}}};
            out_flags_d = 3'b001;
         end else begin
            out_c_d     = {sign2_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
            out_flags_d = 3'b000;
         end
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         sign1_q     <= 1'b0;
         exp1_q      <= '0;
         ma1_q       <= '0;
         mb1_q       <= '0;
         cls1_q      <= '0;
         v2_q        <= 1'b0;
         sign2_q     <= 1'b0;
         exp2_q      <= '0;
         prod2_q     <= '0;
         cls2_q      <= '0;
         out_valid_q <= 1'b0;
         out_c_q     <= '0;
         out_flags_q <= '0;
      end else begin
         v1_q        <= v1_d;
         sign1_q     <= sign1_d;
         exp1_q      <= exp1_d;
         ma1_q       <= ma1_d;
         mb1_q       <= mb1_d;
         cls1_q      <= cls1_d;
         v2_q        <= v2_d;
         sign2_q     <= sign2_d;
         exp2_q      <= exp2_d;
         prod2_q     <= prod2_d;
         cls2_q      <= cls2_d;
         out_valid_q <= out_valid_d;
         out_c_q     <= out_c_d;
         out_flags_q <= out_flags_d;
      end
   end

endmodule
